// File: rtl/history_scan_ctrl.sv
// History-RAM scan controller: clears the RAM, then walks one read per valid pixel
// per frame, with a read-tag pipeline aligned to the RAM latency and a write arbiter.
module history_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_VS,
  input  logic        pixel_valid,
  input  logic        clear_req,
  input  logic [1:0]  threshold_cfg,
  input  logic        det_we,
  input  logic [18:0] det_addr,
  input  logic [3:0]  det_history,
  output logic [18:0] ram_raddr,
  output logic        ram_we,
  output logic [18:0] ram_waddr,
  output logic [3:0]  ram_wdata,
  output logic [18:0] read_addr,
  output logic [9:0]  read_x,
  output logic [9:0]  read_y,
  output logic        rd_valid,
  output logic [1:0]  threshold_history,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned AW   = 19;
  localparam int unsigned CW   = 10;
  localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_WAIT_VS = 2'd1,
    S_SCAN    = 2'd2
  } state_e;

  typedef struct packed {
    logic          valid;
    logic          last;
    logic [AW-1:0] addr;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } rd_tag_t;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          vs_q;
  logic          pend_q, pend_d;
  logic [1:0]    thr_q, thr_d;
  logic          busy_q, busy_d;
  rd_tag_t       iss_q, iss_d;
  rd_tag_t       pipe_q [RD_LAT];
  rd_tag_t       pipe_d [RD_LAT];

  logic vs_fall;
  logic at_end;

  assign vs_fall = vs_q & ~VGA_VS;
  assign at_end  = (x_q == CW'(H_ACTIVE - 1)) && (y_q == CW'(V_ACTIVE - 1));

  // Next-state, scan counters and read-issue tag
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    pend_d     = pend_q;
    thr_d      = thr_q;
    iss_d      = iss_q;
    iss_d.valid = 1'b0;
    iss_d.last  = 1'b0;

    if ((state_q != S_CLEAR) && clear_req) pend_d = 1'b1;

    case (state_q)
      S_CLEAR: begin
        if (clr_addr_q == AW'(NPIX - 1)) begin
          state_d    = S_WAIT_VS;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      S_WAIT_VS: begin
        if (vs_fall) begin
          thr_d = threshold_cfg;
          if (pend_q || clear_req) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_SCAN;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end
        end
      end
      S_SCAN: begin
        // A frame boundary mid-scan restarts the walk; in-flight tags still drain
        if (vs_fall) begin
          thr_d  = threshold_cfg;
          x_d    = '0;
          y_d    = '0;
          addr_d = '0;
        end else if (pixel_valid) begin
          iss_d.valid = 1'b1;
          iss_d.last  = at_end;
          iss_d.addr  = addr_q;
          iss_d.x     = x_q;
          iss_d.y     = y_q;
          addr_d      = addr_q + AW'(1);
          if (x_q == CW'(H_ACTIVE - 1)) begin
            x_d = '0;
            y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
          if (at_end) begin
            state_d = S_WAIT_VS;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase

    if (state_d == S_CLEAR) pend_d = 1'b0;
    busy_d = (state_d == S_CLEAR);

    pipe_d[0] = iss_q;
    for (int i = 1; i < int'(RD_LAT); i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      vs_q       <= 1'b0;
      pend_q     <= 1'b0;
      thr_q      <= '0;
      busy_q     <= 1'b1;
      iss_q      <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vs_q       <= VGA_VS;
      pend_q     <= pend_d;
      thr_q      <= thr_d;
      busy_q     <= busy_d;
      iss_q      <= iss_d;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Write arbiter: the clear engine owns the port while clearing
  always_comb begin
    ram_we    = det_we;
    ram_waddr = det_addr;
    ram_wdata = det_history;
    if (state_q == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end
  end

  assign ram_raddr         = iss_q.addr;
  assign read_addr         = pipe_q[RD_LAT-1].addr;
  assign read_x            = pipe_q[RD_LAT-1].x;
  assign read_y            = pipe_q[RD_LAT-1].y;
  assign rd_valid          = pipe_q[RD_LAT-1].valid;
  assign frame_done        = pipe_q[RD_LAT-1].last;
  assign threshold_history = thr_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_history_scan_ctrl.sv
// Directed bench for history_scan_ctrl on a reduced 8x4 frame with a 2-cycle read latency.
module tb_history_scan_ctrl;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned N = H * V;

  logic        clk = 1'b0;
  logic        reset;
  logic        VGA_VS;
  logic        pixel_valid;
  logic        clear_req;
  logic [1:0]  threshold_cfg;
  logic        det_we;
  logic [18:0] det_addr;
  logic [3:0]  det_history;
  logic [18:0] ram_raddr;
  logic        ram_we;
  logic [18:0] ram_waddr;
  logic [3:0]  ram_wdata;
  logic [18:0] read_addr;
  logic [9:0]  read_x;
  logic [9:0]  read_y;
  logic        rd_valid;
  logic [1:0]  threshold_history;
  logic        busy;
  logic        frame_done;

  history_scan_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .pixel_valid(pixel_valid),
    .clear_req(clear_req), .threshold_cfg(threshold_cfg), .det_we(det_we),
    .det_addr(det_addr), .det_history(det_history), .ram_raddr(ram_raddr),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .read_addr(read_addr), .read_x(read_x), .read_y(read_y), .rd_valid(rd_valid),
    .threshold_history(threshold_history), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vs;
    logic        pv;
    logic [18:0] raddr;
    logic        rv;
    logic [18:0] ra;
    logic [9:0]  rx;
    logic [9:0]  ry;
    logic        fd;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [38:0] rq[$];
  int fd_cnt;
  logic [18:0] fd_addr;

  function automatic vec_t mk(input logic vs, input logic pv, input int raddr,
                              input logic rv, input int ra, input int rx, input int ry);
    vec_t v;
    v.vs = vs; v.pv = pv; v.raddr = 19'(raddr); v.rv = rv;
    v.ra = 19'(ra); v.rx = 10'(rx); v.ry = 10'(ry); v.fd = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and read results logged
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_valid) rq.push_back({read_addr, read_x, read_y});
    if (frame_done) begin
      fd_cnt++;
      fd_addr = read_addr;
    end
  endtask

  // Expects the current sample to show clear address 0; walks the whole clear
  task automatic clear_run(input bit pulse_req);
    if (pulse_req) clear_req = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      chk($sformatf("clear_step_%0d", k), 64'({busy, ram_we, ram_waddr, ram_wdata, rd_valid}),
          64'({1'b1, 1'b1, 19'(k), 4'd0, 1'b0}));
      tick();
      clear_req = 1'b0;
    end
    chk("clear_end_busy", 64'(busy), 64'(0));
  endtask

  function automatic logic [38:0] exp_rd(input int a);
    return {19'(a), 10'(a % int'(H)), 10'(a / int'(H))};
  endfunction

  vec_t tbl[14];

  initial begin
    reset = 1'b0; VGA_VS = 1'b1; pixel_valid = 1'b0; clear_req = 1'b0;
    threshold_cfg = 2'd0; det_we = 1'b0; det_addr = '0; det_history = '0;
    fd_cnt = 0; fd_addr = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_raddr", 64'(ram_raddr), 64'(0));
    chk("rst_read_addr", 64'({read_addr, read_x, read_y}), 64'(0));
    chk("rst_threshold", 64'(threshold_history), 64'(0));
    chk("rst_write_port", 64'({ram_we, ram_waddr, ram_wdata}), 64'({1'b1, 19'd0, 4'd0}));

    // Full clear after reset release, then passthrough in WAIT_VS
    reset = 1'b1;
    clear_run(1'b0);
    det_we = 1'b1; det_addr = 19'd123; det_history = 4'd5;
    #1;
    chk("wait_passthru", 64'({ram_we, ram_waddr, ram_wdata}), 64'({1'b1, 19'd123, 4'd5}));
    det_we = 1'b0;

    // Frame start, bubble, row wrap
    threshold_cfg = 2'd2;
    tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1,  0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1,  1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 2,  1, 1, 1, 0);
    tbl[5]  = mk(0, 1, 3,  0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 4,  1, 2, 2, 0);
    tbl[7]  = mk(0, 1, 5,  1, 3, 3, 0);
    tbl[8]  = mk(0, 1, 6,  1, 4, 4, 0);
    tbl[9]  = mk(0, 1, 7,  1, 5, 5, 0);
    tbl[10] = mk(0, 1, 8,  1, 6, 6, 0);
    tbl[11] = mk(0, 1, 9,  1, 7, 7, 0);
    tbl[12] = mk(0, 1, 10, 1, 8, 0, 1);
    tbl[13] = mk(0, 1, 11, 1, 9, 1, 1);
    for (int i = 0; i < 14; i++) begin
      VGA_VS = tbl[i].vs;
      pixel_valid = tbl[i].pv;
      tick();
      chk($sformatf("v%0d_raddr", i), 64'(ram_raddr), 64'(tbl[i].raddr));
      chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].rv));
      if (tbl[i].rv)
        chk($sformatf("v%0d_read", i), 64'({read_addr, read_x, read_y}),
            64'({tbl[i].ra, tbl[i].rx, tbl[i].ry}));
      chk($sformatf("v%0d_frame_done", i), 64'(frame_done), 64'(tbl[i].fd));
    end
    chk("frame_threshold", 64'(threshold_history), 64'(2));

    // Finish the frame: remaining reads in order, one frame_done on the last pixel
    rq.delete(); fd_cnt = 0;
    for (int i = 0; i < 40; i++) tick();
    chk("frame_tail_count", 64'(rq.size()), 64'(N - 10));
    for (int i = 0; i < rq.size(); i++)
      chk($sformatf("frame_tail_%0d", i), 64'(rq[i]), 64'(exp_rd(10 + i)));
    chk("frame_done_count", 64'(fd_cnt), 64'(1));
    chk("frame_done_addr", 64'(fd_addr), 64'(N - 1));
    chk("frame_threshold_hold", 64'(threshold_history), 64'(2));

    // Frame boundary mid-scan: restart at 0,0, relatch, in-flight reads drain
    VGA_VS = 1'b1; pixel_valid = 1'b0; tick();
    VGA_VS = 1'b0; pixel_valid = 1'b1; threshold_cfg = 2'd1; tick();
    fd_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    VGA_VS = 1'b1; threshold_cfg = 2'd3; tick();
    chk("restart_thr_before", 64'(threshold_history), 64'(1));
    VGA_VS = 1'b0; @(posedge clk); #1;
    rq.delete();
    if (rd_valid) rq.push_back({read_addr, read_x, read_y});
    if (frame_done) fd_cnt++;
    chk("restart_thr_after", 64'(threshold_history), 64'(3));
    for (int i = 0; i < 50; i++) tick();
    chk("restart_count", 64'(rq.size()), 64'(N + 2));
    for (int i = 0; i < rq.size(); i++)
      chk($sformatf("restart_rd_%0d", i), 64'(rq[i]), 64'(exp_rd(i < 2 ? 9 + i : i - 2)));
    chk("restart_frame_done", 64'(fd_cnt), 64'(1));
    chk("restart_fd_addr", 64'(fd_addr), 64'(N - 1));

    // Clear request mid-scan with detector writes active
    threshold_cfg = 2'd0;
    VGA_VS = 1'b1; tick();
    VGA_VS = 1'b0; tick();
    rq.delete(); fd_cnt = 0;
    det_we = 1'b1; det_addr = 19'd77; det_history = 4'd9;
    #1;
    chk("scan_passthru", 64'({ram_we, ram_waddr, ram_wdata}), 64'({1'b1, 19'd77, 4'd9}));
    repeat (5) tick();
    clear_req = 1'b1; tick();
    clear_req = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("pend_scan_reads", 64'(rq.size()), 64'(N));
    chk("pend_frame_done", 64'(fd_cnt), 64'(1));
    chk("pend_wait_busy", 64'(busy), 64'(0));
    VGA_VS = 1'b1; tick();
    VGA_VS = 1'b0; tick();
    clear_run(1'b1);
    det_we = 1'b0;

    // The request made during CLEAR is ignored: next frame scans
    VGA_VS = 1'b1; tick();
    rq.delete(); fd_cnt = 0;
    VGA_VS = 1'b0; tick();
    chk("ignored_req_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 40; i++) tick();
    chk("ignored_req_reads", 64'(rq.size()), 64'(N));
    chk("ignored_req_fd", 64'(fd_cnt), 64'(1));

    // Reset in the middle of a clear restarts it from address 0
    clear_req = 1'b1; tick();
    clear_req = 1'b0;
    VGA_VS = 1'b1; tick();
    VGA_VS = 1'b0; tick();
    repeat (20) tick();
    chk("mid_clear_addr", 64'({busy, ram_waddr}), 64'({1'b1, 19'd20}));
    reset = 1'b0; tick();
    chk("mid_rst_state", 64'({busy, ram_we, ram_waddr, rd_valid}), 64'({1'b1, 1'b1, 19'd0, 1'b0}));
    chk("mid_rst_thr", 64'(threshold_history), 64'(0));
    reset = 1'b1;
    clear_run(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/history_scan_ctrl.md
HISTORY_SCAN_CTRL -- requirements
Module: history_scan_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640: pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: lines per frame.
REQ-003 Parameter RD_LAT, default 2: history-RAM read latency, in cycles.
REQ-004 clk  in  1  single clock; every register SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 VGA_VS  in  1  vertical sync; the frame boundary is its falling edge.
REQ-007 pixel_valid  in  1  upstream median pixel present this cycle; advances the scan.
REQ-008 clear_req  in  1  single-cycle request to zero the history RAM.
REQ-009 threshold_cfg  in  2  software threshold value.
REQ-010 det_we, det_addr[18:0], det_history[3:0]  in  write request from the detector.
REQ-011 ram_raddr  out  19  history-RAM read address.
REQ-012 ram_we, ram_waddr[18:0], ram_wdata[3:0]  out  arbitrated history-RAM write port.
REQ-013 read_addr[18:0], read_x[9:0], read_y[9:0]  out  to detector; aligned with RAM read data.
REQ-014 rd_valid  out  1  read_* outputs carry a valid pixel.
REQ-015 threshold_history  out  2  threshold in force for the current frame.
REQ-016 busy  out  1  asserted while in the CLEAR state.
REQ-017 frame_done  out  1  one-cycle pulse when a full frame scan completes.

Function
REQ-018 The block SHALL implement an FSM with states CLEAR, WAIT_VS and SCAN.
REQ-019 CLEAR SHALL write ram_wdata=0 with ram_we=1 to ram_waddr 0..H_ACTIVE*V_ACTIVE-1, one address per cycle, and then go to WAIT_VS; busy=1 throughout CLEAR.
REQ-020 WAIT_VS SHALL hold until a VGA_VS falling edge, detected against a registered copy of VGA_VS.
REQ-021 On that edge, the FSM SHALL go to CLEAR if a clear is pending, otherwise to SCAN with scan x=0, y=0, and SHALL latch threshold_cfg into threshold_history.
REQ-022 In SCAN, each cycle with pixel_valid=1 SHALL issue ram_raddr=y*H_ACTIVE+x and then advance x; when x wraps from H_ACTIVE-1 to 0, y SHALL increment.
REQ-023 A cycle with pixel_valid=0 SHALL issue no read and SHALL hold x and y.
REQ-024 read_addr, read_x, read_y and rd_valid SHALL be the issued address/coordinates delayed by exactly RD_LAT cycles.
REQ-025 After issuing the read at x=H_ACTIVE-1, y=V_ACTIVE-1, the FSM SHALL go to WAIT_VS.
REQ-026 frame_done SHALL pulse once, in the cycle that the last pixel's rd_valid is asserted.
REQ-027 A VGA_VS falling edge during SCAN SHALL restart the scan at 0,0, relatch the threshold, and produce no frame_done pulse; reads already in the pipeline SHALL still complete.
REQ-028 A clear_req in any state other than CLEAR SHALL set the pending flag.
REQ-029 A clear_req during CLEAR SHALL be ignored.
REQ-030 The pending flag SHALL be cleared on entry to CLEAR.
REQ-031 Write arbitration: in CLEAR the clear engine SHALL own the write port and det_we SHALL be dropped; otherwise ram_we=det_we, ram_waddr=det_addr, ram_wdata=det_history, passed combinationally.
REQ-032 Address arithmetic SHALL be 19-bit unsigned; the maximum address is 307199 and the arithmetic SHALL NOT overflow.
REQ-033 threshold_history SHALL NOT change except at a frame-boundary latch or at reset.

Reset
REQ-034 With reset=0 at a clock edge, the block SHALL enter CLEAR at address 0.
REQ-035 Reset values: x=y=0, the pending flag 0, threshold_history=0, rd_valid=0, the whole read pipeline invalid, frame_done=0, busy=1, ram_raddr=0, read_addr/read_x/read_y=0.
REQ-036 Reset asserted during CLEAR or SCAN SHALL abort the operation and restart CLEAR from address 0.

Verification
REQ-037 Release reset -> busy=1 for exactly 307200 cycles, ram_we=1 with wdata=0 at addresses 0..307199 in order, then WAIT_VS with busy=0.
REQ-038 VS falling edge, threshold_cfg=2, pixel_valid held 1 -> first rd_valid 2 cycles after the first read, with read_x=0, read_y=0; the read at x=639,y=0 is followed by x=0,y=1 (read_addr 640); frame_done pulses once after 307200 valid pixels; threshold_history=2.
REQ-039 pixel_valid toggling 1,0,1 -> the read pipeline shows a bubble, no read_x is skipped or repeated, and read_x sequence 0,1 appears on rd_valid.
REQ-040 clear_req mid-SCAN with det_we active -> the scan finishes and the frame_done pulse is seen; at the next VS edge the FSM enters CLEAR, det_we is dropped (ram_wdata always 0), and no SCAN occurs that frame.
REQ-041 VS falling edge at pixel 1000 of SCAN -> the scan restarts at 0,0, there is no frame_done pulse, and a new threshold_cfg is latched.
REQ-042 Reset asserted at clear address 5000 -> the CLEAR sequence restarts at address 0.
